// File: rtl/alu_pkg.sv
// Shared types for the ALU issue path: opcode constants, ALU op codes,
// the decoded issue entry and the issue buffer occupancy state.
package alu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'b000,
    ALU_SLL  = 3'b001,
    ALU_SLT  = 3'b010,
    ALU_SLTU = 3'b011,
    ALU_XOR  = 3'b100,
    ALU_SRL  = 3'b101,
    ALU_OR   = 3'b110,
    ALU_AND  = 3'b111
  } alu_op_t;

  typedef struct packed {
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    alu_op_t     alu_op;
    logic        alu_sub;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        illegal;
  } issue_entry_t;

  // Encoding equals the entry count, so the state doubles as the count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } fifo_state_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of OP, OP-IMM, LUI and AUIPC into an issue entry;
// anything else becomes an illegal entry with zero operands.
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0]  instr,
  input  logic [31:0]  pc,
  input  logic [31:0]  rs1_data,
  input  logic [31:0]  rs2_data,
  output issue_entry_t entry
);

  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [2:0]  funct3;

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_u  = {instr[31:12], 12'b0};
  assign funct3 = instr[14:12];

  always_comb begin
    entry         = '0;
    entry.rd      = instr[11:7];
    entry.pc      = pc;
    entry.alu_op  = ALU_ADD;
    case (instr[6:0])
      OPC_OP: begin
        entry.alu_a   = rs1_data;
        entry.alu_b   = rs2_data;
        entry.alu_op  = alu_op_t'(funct3);
        entry.alu_sub = ((funct3 == 3'b000) || (funct3 == 3'b101)) ? instr[30] : 1'b0;
      end
      OPC_OP_IMM: begin
        // No SUBI exists, so only the shift-right form reads instr[30].
        entry.alu_a   = rs1_data;
        entry.alu_b   = imm_i;
        entry.alu_op  = alu_op_t'(funct3);
        entry.alu_sub = (funct3 == 3'b101) ? instr[30] : 1'b0;
      end
      OPC_LUI: begin
        entry.alu_b = imm_u;
      end
      OPC_AUIPC: begin
        entry.alu_a = pc;
        entry.alu_b = imm_u;
      end
      default: begin
        entry.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// Decode/issue stage in front of the RV32I ALU: decodes incoming instructions
// and buffers up to two decoded entries behind a valid/ready output port.
//
// Handshake: a transfer happens on a rising edge where valid && ready; the
// sender holds its payload stable while valid && !ready; ready/valid here are
// derived only from registered state.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  output logic        alu_sub,
  output logic [4:0]  out_rd,
  output logic [31:0] out_pc,
  output logic        out_illegal,
  output logic [1:0]  dbg_state
);

  issue_entry_t dec_entry;
  issue_entry_t mem [DEPTH];
  issue_entry_t head_entry;
  fifo_state_t  state;
  logic         head_ptr;
  logic         tail_ptr;
  logic         push;
  logic         pop;

  alu_decode u_decode (
    .instr    (in_instr),
    .pc       (in_pc),
    .rs1_data (in_rs1_data),
    .rs2_data (in_rs2_data),
    .entry    (dec_entry)
  );

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state    <= ST_EMPTY;
      head_ptr <= 1'b0;
      tail_ptr <= 1'b0;
      // Storage is only cleared on reset so the idle outputs read zero.
      if (rst) begin
        mem[0] <= '0;
        mem[1] <= '0;
      end
    end else begin
      if (push) begin
        mem[tail_ptr] <= dec_entry;
        tail_ptr      <= ~tail_ptr;
      end
      if (pop) begin
        head_ptr <= ~head_ptr;
      end
      case (state)
        ST_EMPTY: if (push) state <= ST_ONE;
        ST_ONE: begin
          if (push && !pop)      state <= ST_FULL;
          else if (pop && !push) state <= ST_EMPTY;
        end
        ST_FULL:  if (pop && !push) state <= ST_ONE;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  assign head_entry  = mem[head_ptr];
  assign alu_a       = head_entry.alu_a;
  assign alu_b       = head_entry.alu_b;
  assign alu_op      = head_entry.alu_op;
  assign alu_sub     = head_entry.alu_sub;
  assign out_rd      = head_entry.rd;
  assign out_pc      = head_entry.pc;
  assign out_illegal = head_entry.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed instructions with hand-computed decode
// results, checked in order by a monitor against an expected queue.
module tb_alu_issue_stage;

  localparam int W = 106;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [2:0]  alu_op;
  logic        alu_sub;
  logic [4:0]  out_rd;
  logic [31:0] out_pc;
  logic        out_illegal;
  logic [1:0]  dbg_state;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_data (in_rs1_data),
    .in_rs2_data (in_rs2_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_op      (alu_op),
    .alu_sub     (alu_sub),
    .out_rd      (out_rd),
    .out_pc      (out_pc),
    .out_illegal (out_illegal),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] op, input logic sub,
                                      input logic [4:0] rd, input logic [31:0] pc,
                                      input logic ill);
    return {a, b, op, sub, rd, pc, ill};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
                      input logic [31:0] rs1, input logic [31:0] rs2,
                      input logic [W-1:0] exp);
    bit done = 0;
    in_valid    = 1'b1;
    in_instr    = instr;
    in_pc       = pc;
    in_rs1_data = rs1;
    in_rs2_data = rs2;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        done = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: instr 0x%08h never accepted", instr);
    end
  endtask

  task automatic idle();
    in_valid    = 1'b0;
    in_instr    = $urandom_range(0, 32'h7fff_ffff);
    in_rs1_data = 32'h0;
    in_rs2_data = 32'h0;
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries outstanding, expected 0", exp_q.size());
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      logic [W-1:0] act;
      logic [W-1:0] exp;
      act = {alu_a, alu_b, alu_op, alu_sub, out_rd, out_pc, out_illegal};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got a=%08h b=%08h op=%0d sub=%0b rd=%0d pc=%08h ill=%0b, expected nothing",
                 alu_a, alu_b, alu_op, alu_sub, out_rd, out_pc, out_illegal);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL output: got a=%08h b=%08h op=%0d sub=%0b rd=%0d pc=%08h ill=%0b, expected a=%08h b=%08h op=%0d sub=%0b rd=%0d pc=%08h ill=%0b",
                   alu_a, alu_b, alu_op, alu_sub, out_rd, out_pc, out_illegal,
                   exp[105:74], exp[73:42], exp[41:39], exp[38], exp[37:33], exp[32:1], exp[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b0;
    in_pc = 32'h0;
    idle();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_out_valid", {31'b0, out_valid}, 32'h0);
    check("rst_in_ready", {31'b0, in_ready}, 32'h1);
    check("rst_alu_a", alu_a, 32'h0);
    check("rst_alu_b", alu_b, 32'h0);
    check("rst_out_pc", out_pc, 32'h0);
    check("rst_misc", {22'b0, alu_op, alu_sub, out_rd, out_illegal}, 32'h0);

    // First entry latency: visible the cycle after acceptance
    send(32'h40208033, 32'h0, 32'd10, 32'd3, mk(32'd10, 32'd3, 3'b000, 1'b1, 5'd0, 32'h0, 1'b0));
    idle();
    check("lat_out_valid", {31'b0, out_valid}, 32'h1);
    check("lat_alu_a", alu_a, 32'd10);
    out_ready = 1'b1;
    drain();

    // Decode coverage
    send(32'h40435293, 32'h4, 32'h80000000, 32'h0, mk(32'h80000000, 32'h404, 3'b101, 1'b1, 5'd5, 32'h4, 1'b0));
    send(32'hFFF00093, 32'h8, 32'h0, 32'h0, mk(32'h0, 32'hFFFFFFFF, 3'b000, 1'b0, 5'd1, 32'h8, 1'b0));
    send(32'h12345097, 32'h100, 32'h5555, 32'h0, mk(32'h100, 32'h12345000, 3'b000, 1'b0, 5'd1, 32'h100, 1'b0));
    send(32'h0000057F, 32'h104, 32'hDEAD, 32'hBEEF, mk(32'h0, 32'h0, 3'b000, 1'b0, 5'd10, 32'h104, 1'b1));
    send(32'hABCDE2B7, 32'h108, 32'h1234, 32'h0, mk(32'h0, 32'hABCDE000, 3'b000, 1'b0, 5'd5, 32'h108, 1'b0));
    send(32'h0020C1B3, 32'h10C, 32'hF0F0, 32'h0FF0, mk(32'hF0F0, 32'h0FF0, 3'b100, 1'b0, 5'd3, 32'h10C, 1'b0));
    send(32'h4020D1B3, 32'h110, 32'h80, 32'h2, mk(32'h80, 32'h2, 3'b101, 1'b1, 5'd3, 32'h110, 1'b0));
    idle();
    drain();

    // Back-pressure: two accepts fill the buffer, third is held
    out_ready = 1'b0;
    send(32'h00208033, 32'h200, 32'd1, 32'd2, mk(32'd1, 32'd2, 3'b000, 1'b0, 5'd0, 32'h200, 1'b0));
    send(32'h003100B3, 32'h204, 32'd3, 32'd4, mk(32'd3, 32'd4, 3'b000, 1'b0, 5'd1, 32'h204, 1'b0));
    in_instr = 32'h00418133;
    repeat (2) @(negedge clk);
    check("full_in_ready", {31'b0, in_ready}, 32'h0);
    check("full_state", {30'b0, dbg_state}, 32'd2);
    check("full_hold_pc", out_pc, 32'h200);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(32'h00418133, 32'h208, 32'd5, 32'd6, mk(32'd5, 32'd6, 3'b000, 1'b0, 5'd2, 32'h208, 1'b0));
    idle();
    drain();
    check("after_drain_in_ready", {31'b0, in_ready}, 32'h1);

    // Streaming: one per cycle with occupancy held at one
    for (int i = 0; i < 4; i++) begin
      send(32'h00000013 | (32'(i) << 7), 32'h300 + 32'(i * 4), 32'(i * 7), 32'h0,
           mk(32'(i * 7), 32'h0, 3'b000, 1'b0, 5'(i), 32'h300 + 32'(i * 4), 1'b0));
      check("stream_state", {30'b0, dbg_state}, 32'd1);
      check("stream_in_ready", {31'b0, in_ready}, 32'h1);
    end
    idle();
    drain();

    // Flush while full with a concurrent push
    out_ready = 1'b0;
    send(32'h00208033, 32'h400, 32'd9, 32'd9, mk(32'd9, 32'd9, 3'b000, 1'b0, 5'd0, 32'h400, 1'b0));
    send(32'h00208033, 32'h404, 32'd8, 32'd8, mk(32'd8, 32'd8, 3'b000, 1'b0, 5'd0, 32'h404, 1'b0));
    check("pre_flush_state", {30'b0, dbg_state}, 32'd2);
    exp_q.delete();
    in_valid = 1'b1;
    in_instr = 32'h00208033;
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    idle();
    check("flush_out_valid", {31'b0, out_valid}, 32'h0);
    check("flush_in_ready", {31'b0, in_ready}, 32'h1);
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("post_flush_out_valid", {31'b0, out_valid}, 32'h0);

    // Recovery after flush
    send(32'h00C58533, 32'h500, 32'd20, 32'd22, mk(32'd20, 32'd22, 3'b000, 1'b0, 5'd10, 32'h500, 1'b0));
    idle();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
